// File: rtl/phase_sequence_monitor.sv
// phase_sequence_monitor: checks one-hot p0..p3 rotation, locks after clean rotations, counts locked rotations, flags faults
// Optional feature macro: PHASE_MON_AUTORELOCK_EN (FAULT releases to IDLE after one cycle instead of waiting for clr)
module phase_sequence_monitor #(
    parameter int LOCK_ROTS = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0,
    input  logic             p1,
    input  logic             p2,
    input  logic             p3,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       phase_idx,
    output logic             err,
    output logic             err_sticky,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] rot_cnt
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_FAULT   = 2'd3;
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_ROTS);

    logic [1:0]       r_state;
    logic [1:0]       r_prev_idx;
    logic [1:0]       r_phase_idx;
    logic [1:0]       r_err_code;
    logic [3:0]       r_good;
    logic             r_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_rot_cnt;

    logic [3:0] w_v;
    logic       w_onehot;
    logic [1:0] w_idx;
    logic [1:0] w_exp;
    logic       w_step_ok;
    logic       w_wrap;

    assign w_v       = {p3, p2, p1, p0};
    assign w_onehot  = $onehot(w_v);
    assign w_idx     = {w_v[3] | w_v[2], w_v[3] | w_v[1]};
    assign w_exp     = r_prev_idx + 2'd1;
    assign w_step_ok = w_onehot && (w_idx == w_exp);
    assign w_wrap    = w_step_ok && (w_idx == 2'd0);

    assign locked     = (r_state == S_LOCKED);
    assign phase_idx  = r_phase_idx;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;
    assign err_code   = r_err_code;
    assign rot_cnt    = r_rot_cnt;

    // Sequence FSM plus status/counter registers; a fault on the same edge as clr overrides the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev_idx   <= 2'd0;
            r_phase_idx  <= 2'd0;
            r_err_code   <= 2'b00;
            r_good       <= 4'd0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_rot_cnt    <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_onehot)
                r_phase_idx <= w_idx;
            if (clr) begin
                r_err_sticky <= 1'b0;
                r_err_code   <= 2'b00;
                r_rot_cnt    <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_onehot) begin
                        r_state    <= S_ACQUIRE;
                        r_prev_idx <= w_idx;
                        r_good     <= 4'd0;
                    end
                end
                S_ACQUIRE: begin
                    if (w_step_ok) begin
                        r_prev_idx <= w_idx;
                        if (w_wrap) begin
                            r_good <= r_good + 4'd1;
                            if (r_good + 4'd1 == LOCK_TARGET)
                                r_state <= S_LOCKED;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_good  <= 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (w_step_ok) begin
                        r_prev_idx <= w_idx;
                        if (w_wrap && !clr && !(&r_rot_cnt))
                            r_rot_cnt <= r_rot_cnt + CNT_W'(1);
                    end else begin
                        r_state      <= S_FAULT;
                        r_err        <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_err_code   <= w_onehot ? 2'b10 : 2'b01;
                    end
                end
                default: begin
`ifdef PHASE_MON_AUTORELOCK_EN
                    r_state <= S_IDLE;
`else
                    if (clr)
                        r_state <= S_IDLE;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phase_sequence_monitor.sv
// tb_phase_sequence_monitor: scoreboard bench for phase_sequence_monitor (default and CNT_W=3 instances share stimulus)
module tb_phase_sequence_monitor;
    typedef struct {
        logic       locked;
        logic       err;
        logic       sticky;
        logic [1:0] code;
        logic [1:0] pidx;
        int         rot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, p0, p1, p2, p3, clr;
    logic        locked, err, err_sticky;
    logic [1:0]  phase_idx, err_code;
    logic [15:0] rot_cnt;
    logic        locked3, err3, err_sticky3;
    logic [1:0]  phase_idx3, err_code3;
    logic [2:0]  rot_cnt3;

    exp_t q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    logic       e_locked = 1'b0;
    logic       e_err    = 1'b0;
    logic       e_sticky = 1'b0;
    logic [1:0] e_code   = 2'b00;
    logic [1:0] e_pidx   = 2'd0;
    int         e_rot    = 0;

    phase_sequence_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .clr(clr),
        .locked(locked), .phase_idx(phase_idx), .err(err), .err_sticky(err_sticky),
        .err_code(err_code), .rot_cnt(rot_cnt)
    );

    phase_sequence_monitor #(.LOCK_ROTS(2), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1), .p2(p2), .p3(p3), .clr(clr),
        .locked(locked3), .phase_idx(phase_idx3), .err(err3), .err_sticky(err_sticky3),
        .err_code(err_code3), .rot_cnt(rot_cnt3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Scoreboard: each entry pushed with a stimulus vector is compared after the edge that samples it
    always @(posedge clk) begin
        #2;
        if (q.size() != 0) begin
            m = q.pop_front();
            n_checks += 12;
            if (locked !== m.locked) begin n_errors++; $display("FAIL locked @%0t: got %b want %b", $time, locked, m.locked); end
            if (err !== m.err) begin n_errors++; $display("FAIL err @%0t: got %b want %b", $time, err, m.err); end
            if (err_sticky !== m.sticky) begin n_errors++; $display("FAIL err_sticky @%0t: got %b want %b", $time, err_sticky, m.sticky); end
            if (err_code !== m.code) begin n_errors++; $display("FAIL err_code @%0t: got %b want %b", $time, err_code, m.code); end
            if (phase_idx !== m.pidx) begin n_errors++; $display("FAIL phase_idx @%0t: got %0d want %0d", $time, phase_idx, m.pidx); end
            if (rot_cnt !== 16'(m.rot)) begin n_errors++; $display("FAIL rot_cnt @%0t: got %0d want %0d", $time, rot_cnt, m.rot); end
            if (locked3 !== m.locked) begin n_errors++; $display("FAIL locked3 @%0t: got %b want %b", $time, locked3, m.locked); end
            if (err3 !== m.err) begin n_errors++; $display("FAIL err3 @%0t: got %b want %b", $time, err3, m.err); end
            if (err_sticky3 !== m.sticky) begin n_errors++; $display("FAIL err_sticky3 @%0t: got %b want %b", $time, err_sticky3, m.sticky); end
            if (err_code3 !== m.code) begin n_errors++; $display("FAIL err_code3 @%0t: got %b want %b", $time, err_code3, m.code); end
            if (phase_idx3 !== m.pidx) begin n_errors++; $display("FAIL phase_idx3 @%0t: got %0d want %0d", $time, phase_idx3, m.pidx); end
            if (rot_cnt3 !== 3'(m.rot > 7 ? 7 : m.rot)) begin n_errors++; $display("FAIL rot_cnt3 @%0t: got %0d want %0d", $time, rot_cnt3, (m.rot > 7 ? 7 : m.rot)); end
        end
    end

    task automatic drive(input logic [3:0] v, input logic c);
        @(negedge clk);
        {p3, p2, p1, p0} = v;
        clr = c;
        for (int i = 0; i < 4; i++)
            if (v == 4'(1 << i)) e_pidx = 2'(i);
        q.push_back('{e_locked, e_err, e_sticky, e_code, e_pidx, e_rot});
        e_err = 1'b0;
    endtask

    task automatic lock_up();
        for (int k = 0; k < 9; k++) begin
            if (k == 8) e_locked = 1'b1;
            drive(4'b0001 << (k % 4), 1'b0);
        end
    endtask

    task automatic recover();
        e_sticky = 1'b0;
        e_code   = 2'b00;
        e_rot    = 0;
        drive(4'b0000, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {p3, p2, p1, p0} = 4'b0000;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks += 2;
        if ({locked, err, err_sticky, err_code, phase_idx} !== 7'b0 || rot_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b_%0d want 0000000_0", {locked, err, err_sticky, err_code, phase_idx}, rot_cnt);
        end
        if ({locked3, err3, err_sticky3, err_code3, phase_idx3, rot_cnt3} !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_outputs3: got %b want 0", {locked3, err3, err_sticky3, err_code3, phase_idx3, rot_cnt3});
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int k = 0; k < 13; k++) begin
            if (k == 8) e_locked = 1'b1;
            if (k == 12) e_rot = 1;
            drive(4'b0001 << (k % 4), 1'b0);
        end
    endtask

    task automatic test_order_fault();
        drive(4'b0010, 1'b0);
        e_locked = 1'b0; e_err = 1'b1; e_sticky = 1'b1; e_code = 2'b10;
        drive(4'b1000, 1'b0);
        drive(4'b0000, 1'b0);
`ifdef PHASE_MON_AUTORELOCK_EN
        lock_up();
`else
        for (int k = 0; k < 8; k++)
            drive(4'b0001 << (k % 4), 1'b0);
        recover();
        lock_up();
`endif
    endtask

    task automatic test_onehot_fault();
        e_locked = 1'b0; e_err = 1'b1; e_sticky = 1'b1; e_code = 2'b01;
        drive(4'b0101, 1'b0);
        drive(4'b0000, 1'b0);
        recover();
        lock_up();
        e_sticky = 1'b0; e_code = 2'b00; e_rot = 0;
        drive(4'b0010, 1'b1);
        e_locked = 1'b0; e_err = 1'b1; e_sticky = 1'b1; e_code = 2'b01;
        drive(4'b0000, 1'b0);
        recover();
        lock_up();
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 10; r++)
            for (int k = 1; k <= 4; k++) begin
                if (k == 4) e_rot++;
                drive(4'b0001 << (k % 4), 1'b0);
            end
        e_rot = 0; e_sticky = 1'b0; e_code = 2'b00;
        drive(4'b0010, 1'b1);
        drive(4'b0100, 1'b0);
        drive(4'b1000, 1'b0);
        e_rot = 1;
        drive(4'b0001, 1'b0);
    endtask

    task automatic test_clr_fault();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) e_rot++;
            drive(4'b0001 << (k % 4), 1'b0);
        end
        e_locked = 1'b0; e_err = 1'b1; e_sticky = 1'b1; e_code = 2'b10; e_rot = 0;
        drive(4'b0100, 1'b1);
        recover();
        lock_up();
    endtask

    task automatic test_async_reset();
        drive(4'b0010, 1'b0);
        drive(4'b0100, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if ({locked, err, err_sticky, err_code, phase_idx} !== 7'b0 || rot_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %b_%0d want 0000000_0", {locked, err, err_sticky, err_code, phase_idx}, rot_cnt);
        end
        if ({locked3, err3, err_sticky3, err_code3, phase_idx3, rot_cnt3} !== 10'b0) begin
            n_errors++;
            $display("FAIL async_reset3: got %b want 0", {locked3, err3, err_sticky3, err_code3, phase_idx3, rot_cnt3});
        end
        e_locked = 1'b0; e_sticky = 1'b0; e_code = 2'b00; e_pidx = 2'd0; e_rot = 0;
        @(negedge clk);
        {p3, p2, p1, p0} = 4'b0000;
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        lock_up();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) e_rot = 1;
            drive(4'b0001 << (k % 4), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_order_fault();
        test_onehot_fault();
        test_saturation();
        test_clr_fault();
        test_async_reset();
        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/phase_sequence_monitor.md
# phase_sequence_monitor

- Downstream consumer of the 4-phase clock generator outputs `p0`..`p3`.
- Samples the phase strobes on every `clk` rising edge and checks that exactly one phase is active and that phases rotate p0→p1→p2→p3→p0, advancing one step per `clk` cycle.
- Acquires lock after a programmable number of clean rotations, counts locked rotations, and reports one-hot or ordering faults to the surrounding control logic.

## Interface
- `LOCK_ROTS`, default 2: clean full rotations (3→0 wraps) required to lock; range 1..15.
- `CNT_W`, default 16: width of the rotation counter.

- `clk` in 1: the single clock, shared with the phase generator.
- `rst_n` in 1: reset, asynchronous and active-low.
- `p0`, `p1`, `p2`, `p3` in 1 each: phase strobes from the generator; registered in the `clk` domain upstream.
- `clr` in 1: synchronous clear of error status and rotation counter.
- `locked` out 1: sequence is locked.
- `phase_idx` out 2: index of the last valid one-hot sample.
- `err` out 1: one-cycle fault pulse.
- `err_sticky` out 1: a fault occurred since the last reset or `clr`.
- `err_code` out 2: code of the last fault.
  - 00: none.
  - 01: not one-hot (zero or multiple bits set).
  - 10: out of order.
- `rot_cnt` out CNT_W: locked rotations, saturating.

## Operation
- Sample vector `v={p3,p2,p1,p0}`; it is checked combinationally and all state updates on the same edge.
- `onehot` = exactly one bit of `v` set. `idx` = encoded position of that bit.
- `exp` = `prev_idx+1` mod 4; wrap 3→0 is a legal step.
- `phase_idx` loads `idx` whenever `onehot`; otherwise it holds.
- FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
  - IDLE:
    - `onehot` → ACQUIRE: `prev_idx=idx`, `good=0`.
    - Otherwise stay. No error is reported in IDLE; all-zero vectors during generator start-up are tolerated.
  - ACQUIRE:
    - `onehot && idx==exp`: advance `prev_idx`.
    - On a 3→0 step, `good++`.
    - When `good` reaches LOCK_ROTS → LOCKED.
    - Any other sample → IDLE with `good` cleared. No error is reported.
  - LOCKED:
    - Correct step: stay. On a 3→0 step, `rot_cnt++`, saturating at all-ones.
    - Incorrect step → FAULT.
      - `err`=1 for that cycle.
      - `err_sticky`=1.
      - `err_code`=01 if not one-hot, else 10. Not-one-hot takes priority.
  - FAULT: behaviour depends on configuration (see below).
- `locked`=1 only in LOCKED.
- `clr`:
  - Clears `err_sticky`, `err_code` and `rot_cnt`. Does not affect FSM state.
  - If `clr` and a new fault occur on the same edge, the fault wins: sticky=1, code set, `rot_cnt` cleared.
- `rot_cnt` counts only in LOCKED and holds its value through FAULT and relock.

## Timing
- All outputs are registered; no combinational input→output paths.
- Reset values: `locked`=0, `phase_idx`=0, `err`=0, `err_sticky`=0, `err_code`=00, `rot_cnt`=0, FSM=IDLE, `good`=0.
- Lock latency: the first valid sample moves IDLE→ACQUIRE. `locked` rises after the edge sampling the LOCK_ROTS-th 3→0 step; with first sample p0 that is 4·LOCK_ROTS cycles later.
- `err` rises after the edge that sampled the bad vector, and falls on the next edge.
- `locked` falls on the same edge that `err` rises.
- `rst_n` low mid-operation clears every register immediately; operation resumes in IDLE on the first edge after release.

## Configuration
- Macro `PHASE_MON_AUTORELOCK_EN`:
  - Defined: FAULT lasts exactly one cycle, then moves → IDLE to re-acquire automatically.
  - Undefined: FAULT holds, with `locked`=0, until a cycle with `clr`=1, then moves → IDLE. Additional faults are not re-reported while held.

## Test plan
- Reset, then a clean rotation starting p0, LOCK_ROTS=2 → `locked` rises after the 9th sampling edge. `rot_cnt`=1 after the next 3→0 step. `err` stays 0.
- Locked, then the sequence p1,p3 (p2 skipped) → `err` pulses for 1 cycle, `err_code`=10, `err_sticky`=1, `locked`=0.
  - With the macro: relock 8 cycles after the next p0.
  - Without the macro: stays unlocked until `clr`.
- Locked, then inject `v`=4'b0101 → `err_code`=01. Next, inject 4'b0000 → `err_code`=01 and `phase_idx` holds its last valid value.
- CNT_W=3, locked for 10 rotations → `rot_cnt` saturates at 7. `clr` → `rot_cnt`=0 and counting resumes.
- `clr` on the same edge as an out-of-order fault → `err_sticky`=1, `err_code`=10, `rot_cnt`=0.
- `rst_n` asserted mid-LOCKED, between edges → all outputs 0 immediately. After release with a clean rotation → relock latency is the same as the first scenario.
